hazard_mode_sequencer: RTL



---
 rtl/hazard_mode_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/hazard_mode_sequencer.sv
// Step-enable generator and mode arbiter for the airport hazard-light pattern FSM.
// Tower override beats auto-demo beats manual switches; mode changes land only on step boundaries.
module hazard_mode_sequencer #(
  parameter int TICK_DIV   = 25000000,
  parameter int DEMO_STEPS = 8,
  parameter int HOLD_STEPS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw_mode,
  input  logic       demo_en,
  input  logic       tower_valid,
  input  logic [1:0] tower_mode,
  output logic       tower_ack,
  output logic       step_en,
  output logic [1:0] mode_out,
  output logic       light_reset,
  output logic [1:0] src
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEMO_STEPS + 1);
  localparam int HW = $clog2(HOLD_STEPS + 1);

  // Encoding doubles as the src code seen by the light FSM.
  typedef enum logic [1:0] {
    ST_MANUAL = 2'b00,
    ST_DEMO   = 2'b01,
    ST_TOWER  = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [1:0]    mode_q, mode_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [DW-1:0] demo_q, demo_d;
  logic          primed_q;
  logic          tick;
  logic          step_d, ack_d, lr_d;

  function automatic logic [1:0] map_mode(input logic [1:0] m);
    return (m == 2'b11) ? 2'b00 : m;
  endfunction

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      state_q     <= ST_MANUAL;
      mode_q      <= 2'b00;
      hold_q      <= '0;
      demo_q      <= '0;
      primed_q    <= 1'b0;
      step_en     <= 1'b0;
      tower_ack   <= 1'b0;
      light_reset <= 1'b1;
    end else begin
      cnt_q       <= tick ? '0 : cnt_q + CW'(1);
      state_q     <= state_d;
      mode_q      <= mode_d;
      hold_q      <= hold_d;
      demo_q      <= demo_d;
      primed_q    <= primed_q | tick;
      step_en     <= step_d;
      tower_ack   <= ack_d;
      light_reset <= lr_d;
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    hold_d  = hold_q;
    demo_d  = demo_q;
    if (tick) begin
      if (tower_valid) begin
        state_d = ST_TOWER;
        mode_d  = map_mode(tower_mode);
        hold_d  = HW'(HOLD_STEPS);
      end else begin
        case (state_q)
          ST_TOWER: begin
            if (hold_q != '0) begin
              hold_d = hold_q - HW'(1);
            end else if (demo_en) begin
              state_d = ST_DEMO;
              mode_d  = 2'b00;
              demo_d  = '0;
            end else begin
              state_d = ST_MANUAL;
              mode_d  = map_mode(sw_mode);
            end
          end
          ST_DEMO: begin
            if (!demo_en) begin
              state_d = ST_MANUAL;
              mode_d  = map_mode(sw_mode);
            end else if (demo_q == DW'(DEMO_STEPS - 1)) begin
              demo_d = '0;
              mode_d = (mode_q == 2'b10) ? 2'b00 : mode_q + 2'b01;
            end else begin
              demo_d = demo_q + DW'(1);
            end
          end
          default: begin
            if (demo_en) begin
              state_d = ST_DEMO;
              mode_d  = 2'b00;
              demo_d  = '0;
            end else begin
              mode_d = map_mode(sw_mode);
            end
          end
        endcase
      end
    end
  end

  // Pattern restart is held from reset through the first step, then only on mode changes.
  always_comb begin
    step_d = tick;
    ack_d  = tick & tower_valid;
    lr_d   = tick ? (!primed_q || (mode_d != mode_q)) : !primed_q;
  end

  assign mode_out = mode_q;
  assign src      = state_q;

endmodule
